// File: rtl/i2c_master_engine.sv
// i2c_master_engine: byte-level 7-bit I2C master driving open-drain SCL/SDA enables.
module i2c_master_engine #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] num_bytes,
    input  logic       start_wr,
    input  logic       start_rd,
    input  logic [7:0] wr_data,
    input  logic       wr_data_valid,
    output logic       req_data_chunk,
    output logic [7:0] rd_data,
    output logic       rd_data_valid,
    output logic       busy,
    output logic       nack,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WAIT_DATA, WDATA, ACK_W,
        RSTART, ADDR_R, ACK_AR, RDATA, MACK, STOP
    } state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [1:0] q;
    logic [2:0] bit_cnt;
    logic [7:0] tx, rx, nbytes, reg_q;
    logic [6:0] dev_q;
    logic wr_mode;

    logic tick, q_end, sample, byte_done, sack_st, tx_st, accept;
    assign tick      = cnt == CW'(CLK_DIV - 1);
    assign q_end     = tick && q == 2'd3;
    assign sample    = q == 2'd3 && cnt == '0;
    assign byte_done = q_end && bit_cnt == 3'd7;
    assign sack_st   = state inside {ACK_A, ACK_R, ACK_W, ACK_AR};
    assign tx_st     = state inside {ADDR_W, REG, WDATA, ADDR_R};
    assign accept    = state == IDLE && (start_wr || start_rd);

    assign req_data_chunk = state == WAIT_DATA;
    assign busy           = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // nack is sticky per transaction, so inside an ACK slot it reflects only that slot
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (accept) state_nx = START;
            START:     if (tick && q == 2'd1) state_nx = ADDR_W;
            ADDR_W:    if (byte_done) state_nx = ACK_A;
            ACK_A:     if (q_end) state_nx = nack ? STOP : REG;
            REG:       if (byte_done) state_nx = ACK_R;
            ACK_R:     if (q_end) state_nx = (nack || nbytes == 8'd0) ? STOP : wr_mode ? WAIT_DATA : RSTART;
            WAIT_DATA: if (wr_data_valid) state_nx = WDATA;
            WDATA:     if (byte_done) state_nx = ACK_W;
            ACK_W:     if (q_end) state_nx = (nack || nbytes == 8'd1) ? STOP : WAIT_DATA;
            RSTART:    if (q_end) state_nx = ADDR_R;
            ADDR_R:    if (byte_done) state_nx = ACK_AR;
            ACK_AR:    if (q_end) state_nx = nack ? STOP : RDATA;
            RDATA:     if (byte_done) state_nx = MACK;
            MACK:      if (q_end) state_nx = nbytes == 8'd1 ? STOP : RDATA;
            STOP:      if (tick && q == 2'd2) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state)
            IDLE:      ;
            START:     begin scl_oe = q == 2'd1; sda_oe = 1'b1; end
            RSTART:    begin scl_oe = q == 2'd0 || q == 2'd3; sda_oe = q[1]; end
            STOP:      begin scl_oe = q == 2'd0; sda_oe = q != 2'd2; end
            WAIT_DATA: scl_oe = 1'b1;
            default: begin
                scl_oe = !q[1];
                sda_oe = tx_st ? !tx[7] : state == MACK && nbytes != 8'd1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            q             <= 2'd0;
            bit_cnt       <= 3'd0;
            tx            <= 8'd0;
            rx            <= 8'd0;
            nbytes        <= 8'd0;
            reg_q         <= 8'd0;
            dev_q         <= 7'd0;
            wr_mode       <= 1'b0;
            nack          <= 1'b0;
            rd_data       <= 8'd0;
            rd_data_valid <= 1'b0;
        end else begin
            rd_data_valid <= 1'b0;
            if (state_nx != state) begin
                cnt     <= '0;
                q       <= 2'd0;
                bit_cnt <= 3'd0;
            end else if (state != IDLE && state != WAIT_DATA) begin
                cnt <= tick ? '0 : cnt + 1'b1;
                if (tick) q <= q + 1'b1;
                if (q_end) bit_cnt <= bit_cnt + 1'b1;
            end
            if (accept) begin
                dev_q   <= dev_addr;
                reg_q   <= reg_addr;
                nbytes  <= num_bytes;
                wr_mode <= start_wr;
                nack    <= 1'b0;
            end
            if (sack_st && sample && sda_i) nack <= 1'b1;
            if (state_nx != state)
                tx <= state_nx == ADDR_W ? {dev_q, 1'b0} :
                      state_nx == REG    ? reg_q :
                      state_nx == WDATA  ? wr_data :
                      state_nx == ADDR_R ? {dev_q, 1'b1} : tx;
            else if (q_end)
                tx <= {tx[6:0], 1'b0};
            if (state == RDATA && sample) begin
                rx <= {rx[6:0], sda_i};
                if (bit_cnt == 3'd7) begin
                    rd_data       <= {rx[6:0], sda_i};
                    rd_data_valid <= 1'b1;
                end
            end
            if ((state == ACK_W || state == MACK) && q_end) nbytes <= nbytes - 1'b1;
        end
    end
endmodule

// File: tb/tb_i2c_master_engine.sv
// tb_i2c_master_engine: transaction table against a bit-level slave model on the bus,
// with bus tokens and read bytes checked through scoreboard queues.
module tb_i2c_master_engine;
    localparam int CLK_DIV = 4;
    localparam logic [15:0] TOK_S = 16'h100, TOK_P = 16'h200, TOK_A = 16'h400;

    logic clk = 1'b0, rst = 1'b1;
    logic [6:0] dev_addr = '0;
    logic [7:0] reg_addr = '0, num_bytes = '0, wr_data = '0;
    logic start_wr = 1'b0, start_rd = 1'b0, wr_data_valid = 1'b0;
    logic req_data_chunk, rd_data_valid, busy, nack, scl_oe, sda_oe, sda_i;
    logic [7:0] rd_data;
    logic slave_sda = 1'b1;
    bit nack_addr_mode = 1'b0;

    int n_checks = 0, n_fails = 0;
    logic [15:0] exp_bus[$];
    logic [7:0] exp_rd[$];
    logic [7:0] slave_tx[$];

    always #5 clk = ~clk;
    assign sda_i = !sda_oe && slave_sda;

    i2c_master_engine #(.CLK_DIV(CLK_DIV)) dut (
        .clk(clk), .rst(rst), .dev_addr(dev_addr), .reg_addr(reg_addr), .num_bytes(num_bytes),
        .start_wr(start_wr), .start_rd(start_rd), .wr_data(wr_data), .wr_data_valid(wr_data_valid),
        .req_data_chunk(req_data_chunk), .rd_data(rd_data), .rd_data_valid(rd_data_valid),
        .busy(busy), .nack(nack), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fails++;
            $display("FAIL %s: got %0h, wanted %0h", nm, act, expv);
        end
    endtask

    task automatic obs_bus(input logic [15:0] t);
        if (exp_bus.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL bus_token: got %0h, wanted nothing", t);
        end else check("bus_token", t, exp_bus.pop_front());
    endtask

    // Slave model and monitors, evaluated on the falling clk edge
    initial begin
        logic scl, sda, scl_p, sda_p, first, was_addr, rdm;
        logic [7:0] sh, rbyte;
        int bitn;
        scl_p = 1; sda_p = 1; first = 1; was_addr = 0; rdm = 0; sh = 0; rbyte = 8'hFF; bitn = 0;
        forever begin
            @(negedge clk);
            scl = !scl_oe;
            sda = !sda_oe && slave_sda;
            if (rst) begin
                bitn = 0; first = 1; rdm = 0; slave_sda = 1'b1;
            end else if (scl && scl_p && sda_p && !sda) begin
                obs_bus(TOK_S); bitn = 0; first = 1; rdm = 0;
            end else if (scl && scl_p && !sda_p && sda) begin
                obs_bus(TOK_P); bitn = 0; first = 1; rdm = 0;
            end else if (scl && !scl_p) begin
                if (bitn < 8) begin
                    sh = {sh[6:0], sda};
                    bitn++;
                    if (bitn == 8) begin
                        was_addr = first;
                        if (first) rdm = sh[0];
                        first = 0;
                        if (!rdm || was_addr) obs_bus({8'h00, sh});
                    end
                end else begin
                    if (rdm && !was_addr) obs_bus(TOK_A | 16'(sda));
                    bitn = 0;
                end
            end else if (!scl && scl_p) begin
                if (bitn == 8)
                    slave_sda = (!rdm || was_addr) ? (was_addr && nack_addr_mode) : 1'b1;
                else if (rdm && !first) begin
                    if (bitn == 0) rbyte = slave_tx.size() != 0 ? slave_tx.pop_front() : 8'hFF;
                    slave_sda = rbyte[7-bitn];
                end else slave_sda = 1'b1;
            end
            if (!rst && rd_data_valid) begin
                if (exp_rd.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL rd_data: got %0h, wanted no strobe", rd_data);
                end else check("rd_data", rd_data, exp_rd.pop_front());
            end
            scl_p = scl;
            sda_p = sda;
        end
    end

    typedef struct {
        bit wr; bit both; logic [6:0] dev; logic [7:0] ra; logic [7:0] num;
        logic [7:0] d0; logic [7:0] d1; bit nack_a; int stall; bit poke;
    } txn_t;
    txn_t tbl[8];

    task automatic run_txn(input txn_t t);
        logic [7:0] data[2];
        bit isw;
        int idx, stall_cnt, cyc, n_exp;
        bit stall_bad;
        data[0] = t.d0; data[1] = t.d1;
        isw = t.wr || t.both;
        nack_addr_mode = t.nack_a;
        slave_tx.delete();
        exp_bus.push_back(TOK_S);
        exp_bus.push_back({8'h00, t.dev, 1'b0});
        if (!t.nack_a) begin
            exp_bus.push_back({8'h00, t.ra});
            if (t.num != 0 && isw)
                for (int i = 0; i < int'(t.num); i++) exp_bus.push_back({8'h00, data[i]});
            if (t.num != 0 && !isw) begin
                exp_bus.push_back(TOK_S);
                exp_bus.push_back({8'h00, t.dev, 1'b1});
                for (int i = 0; i < int'(t.num); i++) begin
                    slave_tx.push_back(data[i]);
                    exp_rd.push_back(data[i]);
                    exp_bus.push_back(TOK_A | 16'(i == int'(t.num) - 1));
                end
            end
        end
        exp_bus.push_back(TOK_P);
        n_exp = (isw && !t.nack_a) ? int'(t.num) : 0;
        @(posedge clk); #1;
        dev_addr = t.dev; reg_addr = t.ra; num_bytes = t.num;
        start_wr = isw; start_rd = !t.wr;
        @(posedge clk); #1;
        start_wr = 0; start_rd = 0;
        dev_addr = 7'h00; reg_addr = 8'hEE; num_bytes = 8'hFF;
        check("busy_after_start", busy, 1'b1);
        check("nack_cleared_on_start", nack, 1'b0);
        idx = 0; stall_cnt = 0; cyc = 0; stall_bad = 0;
        while (busy && cyc < 20000) begin
            start_rd = t.poke && cyc == 20;
            if (req_data_chunk) begin
                if (stall_cnt < t.stall) begin
                    stall_cnt++;
                    if (!scl_oe) stall_bad = 1;
                    wr_data_valid = 0;
                end else begin
                    wr_data = idx < 2 ? data[idx] : 8'h00;
                    wr_data_valid = 1;
                    idx++;
                end
            end else wr_data_valid = 0;
            @(posedge clk); #1;
            cyc++;
        end
        wr_data_valid = 0; start_rd = 0;
        check("txn_finished", busy, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("idle_after_stop", {busy, scl_oe, sda_oe}, 3'b000);
        check("nack_status", nack, t.nack_a);
        check("wr_bytes_fetched", idx, n_exp);
        check("bus_tokens_left", exp_bus.size(), 0);
        check("rd_bytes_left", exp_rd.size(), 0);
        if (t.stall > 0) begin
            check("stall_scl_held", stall_bad, 1'b0);
            check("stall_cycles", stall_cnt, t.stall);
        end
    endtask

    initial begin
        //           wr both dev    reg    num   d0     d1   nack stall poke
        tbl[0] = '{1, 0, 7'h5B, 8'h00, 8'd2, 8'hA5, 8'h3C, 0, 0, 0};
        tbl[1] = '{0, 0, 7'h5B, 8'h10, 8'd2, 8'h12, 8'h34, 0, 0, 0};
        tbl[2] = '{1, 0, 7'h5B, 8'h20, 8'd2, 8'h11, 8'h22, 1, 0, 0};
        tbl[3] = '{1, 0, 7'h3C, 8'h7F, 8'd1, 8'h81, 8'h00, 0, 50, 0};
        tbl[4] = '{1, 0, 7'h01, 8'h55, 8'd0, 8'h00, 8'h00, 0, 0, 0};
        tbl[5] = '{0, 0, 7'h7F, 8'h80, 8'd0, 8'h00, 8'h00, 0, 0, 1};
        tbl[6] = '{0, 1, 7'h2A, 8'h0F, 8'd1, 8'hC3, 8'h00, 0, 0, 0};
        tbl[7] = '{0, 0, 7'h48, 8'h01, 8'd1, 8'h96, 8'h00, 0, 0, 0};
        repeat (3) @(posedge clk);
        #1;
        check("reset_oe", {scl_oe, sda_oe}, 2'b00);
        check("reset_busy", busy, 1'b0);
        check("reset_nack", nack, 1'b0);
        check("reset_req", req_data_chunk, 1'b0);
        check("reset_rd", {rd_data_valid, rd_data}, 9'd0);
        rst = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                nack_addr_mode = 0;
                exp_bus.push_back(TOK_S);
                exp_bus.push_back(16'h00B6);
                @(posedge clk); #1;
                dev_addr = 7'h5B; reg_addr = 8'hAA; num_bytes = 8'd1; start_wr = 1;
                @(posedge clk); #1;
                start_wr = 0;
                repeat (190) @(posedge clk);
                #1;
                check("busy_mid_reg", busy, 1'b1);
                rst = 1;
                @(posedge clk); #1;
                check("rst_mid_oe", {scl_oe, sda_oe}, 2'b00);
                check("rst_mid_busy", busy, 1'b0);
                check("rst_mid_nack", nack, 1'b0);
                @(posedge clk); #1;
                rst = 0;
                check("rst_bus_tokens_left", exp_bus.size(), 0);
            end
            run_txn(tbl[i]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
